led_sequencer: RTL and testbench

Command-driven LED pattern scheduler for the iCEstick's five user LEDs (D1–D5). It steps a selectable built-in pattern at a fixed rate derived from the 12 MHz board clock. A single-command valid/ready port starts, pauses, stops and re-selects the pattern. It sits between board-level control logic (button debouncer, UART command decoder) and the LED pins, replacing free-running blink counters.

---
 rtl/led_seq_pkg.sv | 46 ++++
 rtl/led_tick_gen.sv | 43 ++++
 rtl/led_sequencer.sv | 151 +++++++++++++++
 tb/tb_led_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   - command opcodes carried on cmd_op
//   - sequencer state type
//   - built-in pattern identifiers and the ping-pong position table
//   - pattern_leds(): maps (pattern, step) to the five LED bits, bit 0 = D1
// -----------------------------------------------------------------------------
package led_seq_pkg;

    localparam logic [1:0] OP_STOP   = 2'd0;
    localparam logic [1:0] OP_START  = 2'd1;
    localparam logic [1:0] OP_PAUSE  = 2'd2;
    localparam logic [1:0] OP_SELECT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] PAT_BINARY   = 2'd0;
    localparam logic [1:0] PAT_WALK     = 2'd1;
    localparam logic [1:0] PAT_FLASH    = 2'd2;
    localparam logic [1:0] PAT_PINGPONG = 2'd3;

    // Lit LED index for ping-pong, indexed by step[2:0]: 0,1,2,3,4,3,2,1.
    // Element 0 is the rightmost entry of the packed array.
    localparam logic [7:0][2:0] PP_POS = {3'd1, 3'd2, 3'd3, 3'd4,
                                          3'd3, 3'd2, 3'd1, 3'd0};

    function automatic logic [4:0] pattern_leds(input logic [1:0] pat,
                                                input logic [3:0] s);
        logic [4:0] leds;
        leds = '0;
        case (pat)
            PAT_BINARY:   leds = {(s == 4'd0), s};
            PAT_WALK:     leds = 5'b00001 << (s % 4'd5);
            PAT_FLASH:    leds = {5{s[0]}};
            PAT_PINGPONG: leds = 5'b00001 << PP_POS[s[2:0]];
            default:      leds = '0;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Step-rate prescaler. Counts 0 .. CLK_HZ/STEP_HZ-1 while enabled and emits a
// one-cycle tick on the terminal count, wrapping to 0 on the same edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (counter frozen when low)
//   clr        : synchronous clear to 0, overrides en
//   tick       : high during the terminal-count cycle while enabled
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int CLK_HZ  = 12000000,
    parameter int STEP_HZ = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PERIOD = CLK_HZ / STEP_HZ;
    localparam int              CW     = $clog2(PERIOD);
    localparam logic [CW-1:0]   LAST   = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation results that synthesis does not reproduce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Command-driven LED pattern scheduler for five LEDs (D1..D5).
// Optional feature macro: LED_SEQ_PWM_EN adds the bright input and a
// free-running 4-bit PWM gate applied after the LED output register.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : single-command handshake (accept = valid && ready)
//   cmd_op              : 0 STOP, 1 START, 2 PAUSE, 3 SELECT
//   cmd_pat             : pattern id for SELECT
//   busy                : high in RUN or PAUSE
//   step_idx            : current 4-bit step counter
//   D1..D5              : registered LED drives, active high
//   bright              : PWM duty 0..15 (LED_SEQ_PWM_EN only)
// -----------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ  = 12000000,
    parameter int STEP_HZ = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_pat,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       D4,
    output logic       D5
`ifdef LED_SEQ_PWM_EN
    ,
    input  logic [3:0] bright
`endif
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_pat,   w_pat_nxt;
    logic [3:0] r_step,  w_step_nxt;
    logic       r_ready;
    logic [4:0] r_led;
    logic [4:0] w_led_out;
    logic       w_accept;
    logic       w_tick;
    logic       w_clr;
    logic       w_run;

    assign w_accept = cmd_valid && r_ready;
    assign w_run    = (r_state == ST_RUN);

    led_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_step_nxt  = w_tick ? r_step + 4'd1 : r_step;
        w_clr       = (r_state == ST_IDLE);

        // An effective command overrides the step update, discarding a
        // coincident tick. START in RUN changes nothing, so the tick survives.
        if (w_accept) begin
            case (cmd_op)
                OP_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                    w_clr       = 1'b1;
                end
                OP_START: begin
                    if (r_state == ST_IDLE) begin
                        w_state_nxt = ST_RUN;
                        w_step_nxt  = '0;
                        w_clr       = 1'b1;
                    end else if (r_state == ST_PAUSE) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                OP_PAUSE: begin
                    if (r_state == ST_RUN) begin
                        w_state_nxt = ST_PAUSE;
                        w_step_nxt  = r_step;
                    end
                end
                default: begin
                    w_pat_nxt  = cmd_pat;
                    w_step_nxt = '0;
                    w_clr      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pat   <= PAT_BINARY;
            r_step  <= '0;
            r_ready <= 1'b1;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_step  <= w_step_nxt;
            // Ready drops for the single cycle following an acceptance.
            r_ready <= !w_accept;
            // Decode from the registered state/step, so LEDs trail them by one
            // cycle; PAUSE keeps the last value loaded while running.
            case (r_state)
                ST_RUN:   r_led <= pattern_leds(r_pat, r_step);
                ST_IDLE:  r_led <= '0;
                default:  r_led <= r_led;
            endcase
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_led_out = r_led & {5{r_pwm_cnt < bright}};
`else
    assign w_led_out = r_led;
`endif

    assign cmd_ready = r_ready;
    assign busy      = (r_state != ST_IDLE);
    assign step_idx  = r_step;
    assign {D5, D4, D3, D2, D1} = w_led_out;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
// Self-checking bench for led_sequencer with CLK_HZ = 40, STEP_HZ = 4
// (10 cycles per step). A behavioural model tracks mode, step, phase within
// the step period, pattern and expected LED value; every cycle the DUT
// outputs are compared against it, with directed checks for the timing points
// of interest. A randomized command phase follows the directed sequence.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_pat;
    logic       busy;
    logic [3:0] step_idx;
    logic       D1, D2, D3, D4, D5;
`ifdef LED_SEQ_PWM_EN
    logic [3:0] bright;
`endif

    led_sequencer #(
        .CLK_HZ  (40),
        .STEP_HZ (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_pat   (cmd_pat),
        .busy      (busy),
        .step_idx  (step_idx),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .D4        (D4),
        .D5        (D5)
`ifdef LED_SEQ_PWM_EN
        ,
        .bright    (bright)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    // Model: mode 0 = idle, 1 = run, 2 = pause.
    int         m_mode, m_step, m_pat, m_phase, m_pwm;
    logic       m_ready;
    logic [4:0] m_led;

    int pp_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    function automatic logic [4:0] exp_leds(input int pat, input int s);
        int r;
        case (pat)
            0:       r = (s % 16) + ((s == 0) ? 16 : 0);
            1:       r = 1 << (s % 5);
            2:       r = ((s % 2) == 1) ? 31 : 0;
            default: r = 1 << pp_seq[s % 8];
        endcase
        return 5'(r);
    endfunction

    function automatic logic [4:0] gate(input logic [4:0] raw);
`ifdef LED_SEQ_PWM_EN
        return (m_pwm < int'(bright)) ? raw : 5'd0;
`else
        return raw;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_pat = 0; m_phase = 0; m_pwm = 0;
        m_ready = 1'b1; m_led = '0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] op, input logic [1:0] pat);
        logic       acc;
        logic [4:0] led_n;
        bit         tk;
        int         ph_n, st_n, mode_n, pat_n;
        acc    = v && m_ready;
        led_n  = (m_mode == 1) ? exp_leds(m_pat, m_step) : ((m_mode == 0) ? 5'd0 : m_led);
        tk     = (m_mode == 1) && (m_phase == PERIOD - 1);
        ph_n   = (m_mode == 1) ? (m_phase + 1) % PERIOD : m_phase;
        st_n   = tk ? (m_step + 1) % 16 : m_step;
        mode_n = m_mode;
        pat_n  = m_pat;
        if (acc) begin
            case (op)
                2'd0: begin mode_n = 0; st_n = 0; ph_n = 0; end
                2'd1: begin
                    if (m_mode == 0) begin mode_n = 1; st_n = 0; ph_n = 0; end
                    else if (m_mode == 2) mode_n = 1;
                end
                2'd2: if (m_mode == 1) begin mode_n = 2; st_n = m_step; end
                default: begin pat_n = int'(pat); st_n = 0; ph_n = 0; end
            endcase
        end
        m_mode  = mode_n;
        m_step  = st_n;
        m_pat   = pat_n;
        m_phase = ph_n;
        m_ready = !acc;
        m_led   = led_n;
        m_pwm   = (m_pwm + 1) % 16;
    endtask

    task automatic check_all();
        chk("ready", 32'(cmd_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("step", 32'(step_idx), 32'(m_step));
        chk("leds", 32'({D5, D4, D3, D2, D1}), 32'(gate(m_led)));
    endtask

    // One clock cycle: drive inputs, advance model on the edge, check at +1.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [1:0] pat);
        cmd_valid = v;
        cmd_op    = op;
        cmd_pat   = pat;
        if (v && cmd_ready) n_acc++;
        @(posedge clk);
        model_edge(v, op, pat);
        #1;
        check_all();
    endtask

    initial begin
        int         s0, s1, n0, d5_cnt, guard;
        logic [1:0] r_op;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_pat   = 2'd0;
`ifdef LED_SEQ_PWM_EN
        bright    = 4'hF;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_leds", 32'({D5, D4, D3, D2, D1}), 32'd0);
        rst_n = 1'b1;

        // START from IDLE: busy next edge, step 1 after 10 cycles, 2 after 20.
        cyc(1'b1, 2'd1, 2'd0);
        chk("start_busy", 32'(busy), 32'd1);
        repeat (9) cyc(1'b0, 2'd0, 2'd0);
        chk("step_before_first", 32'(step_idx), 32'd0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("first_step", 32'(step_idx), 32'd1);
        cyc(1'b0, 2'd0, 2'd0);
        chk("d1_after_step1", 32'({D5, D4, D3, D2, D1}), 32'(gate(5'b00001)));
        repeat (9) cyc(1'b0, 2'd0, 2'd0);
        chk("second_step", 32'(step_idx), 32'd2);

        // Wrap 15 -> 0 -> 1 -> 2; D5 lit for exactly one step period.
        d5_cnt = 0;
        for (int i = 0; i < 16 * PERIOD; i++) begin
            cyc(1'b0, 2'd0, 2'd0);
            if (D5) d5_cnt++;
        end
        chk("wrap_step", 32'(step_idx), 32'd2);
`ifndef LED_SEQ_PWM_EN
        chk("d5_period", 32'(d5_cnt), 32'(PERIOD));
`endif

        // PAUSE with prescaler landing on 6, hold 50 cycles, resume.
        repeat (5) cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b1, 2'd2, 2'd0);
        chk("pause_busy", 32'(busy), 32'd1);
        s0 = m_step;
        repeat (50) cyc(1'b0, 2'd0, 2'd0);
        chk("pause_hold_step", 32'(step_idx), 32'(s0));
        chk("pause_hold_leds", 32'({D5, D4, D3, D2, D1}), 32'(gate(exp_leds(0, s0))));
        cyc(1'b1, 2'd1, 2'd0);
        repeat (3) cyc(1'b0, 2'd0, 2'd0);
        chk("resume_early", 32'(step_idx), 32'(s0));
        cyc(1'b0, 2'd0, 2'd0);
        chk("resume_step", 32'(step_idx), 32'((s0 + 1) % 16));

        // SELECT walk in RUN: step cleared, D1..D5 then D1 again.
        cyc(1'b1, 2'd3, 2'd1);
        chk("select_step", 32'(step_idx), 32'd0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("walk_0", 32'({D5, D4, D3, D2, D1}), 32'(gate(5'b00001)));
        for (int k = 1; k <= 5; k++) begin
            repeat (PERIOD) cyc(1'b0, 2'd0, 2'd0);
            chk($sformatf("walk_%0d", k), 32'({D5, D4, D3, D2, D1}),
                32'(gate(5'(1 << (k % 5)))));
        end

        // cmd_valid held over START then PAUSE; PAUSE lands on a tick cycle.
        guard = 0;
        while (m_phase != PERIOD - 3 && guard < 3 * PERIOD) begin
            cyc(1'b0, 2'd0, 2'd0);
            guard++;
        end
        chk("align_guard", 32'(m_phase), 32'(PERIOD - 3));
        n0 = n_acc;
        s1 = m_step;
        chk("held_ready_0", 32'(cmd_ready), 32'd1);
        cyc(1'b1, 2'd1, 2'd0);
        chk("held_ready_1", 32'(cmd_ready), 32'd0);
        cyc(1'b1, 2'd2, 2'd0);
        chk("held_ready_2", 32'(cmd_ready), 32'd1);
        cyc(1'b1, 2'd2, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("held_accepts", 32'(n_acc - n0), 32'd2);
        chk("tick_dropped", 32'(step_idx), 32'(s1));

        // Ping-pong in RUN, then asynchronous reset mid-cycle.
        cyc(1'b1, 2'd1, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b1, 2'd3, 2'd3);
        repeat (25) cyc(1'b0, 2'd0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_step", 32'(step_idx), 32'd0);
        chk("async_rst_leds", 32'({D5, D4, D3, D2, D1}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

`ifdef LED_SEQ_PWM_EN
        // Hold D5 lit via PAUSE, then measure duty at bright = 4.
        cyc(1'b1, 2'd1, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b1, 2'd2, 2'd0);
        bright = 4'd4;
        d5_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 2'd0, 2'd0);
            if (D5) d5_cnt++;
        end
        chk("pwm_duty", 32'(d5_cnt), 32'd4);
        bright = 4'hF;
        cyc(1'b1, 2'd0, 2'd0);
`endif

        // Randomized command traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r_op = 2'($urandom_range(3));
            if (r_op == 2'd0 && $urandom_range(1) == 1) r_op = 2'd1;
            cyc(($urandom_range(2) == 0), r_op, 2'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
